// File: rtl/piso_mux_seq8_pkg.sv
// Shared types and constants for the piso_mux_seq8 parallel-to-serial sequencer.
package piso_mux_seq8_pkg;

  localparam int WORD_BITS = 8;
  localparam int SEL_W     = 3;
  localparam int GAP_W     = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_e;

  // Maps the transfer index onto the mux select for the chosen bit order.
  function automatic logic [SEL_W-1:0] order_sel(input logic [SEL_W-1:0] count,
                                                 input logic            msb_first);
    return count ^ {SEL_W{msb_first}};
  endfunction

endpackage

// File: rtl/piso_mux_seq8_mux8x1.sv
// Gate-level 8:1 multiplexer: one-hot decode of s, AND with d, OR-reduce to Y.
module mux8x1 (
  input  logic [7:0] d,
  input  logic [2:0] s,
  output logic       Y
);

  logic [7:0] sel_hot;

  for (genvar i = 0; i < 8; i++) begin : g_dec
    assign sel_hot[i] = (s == 3'(i));
  end

  assign Y = |(d & sel_hot);

endmodule

// File: rtl/piso_mux_seq8.sv
// Sequencer feeding mux8x1: latches a word, steps the select, streams one bit per transfer.
module piso_mux_seq8
  import piso_mux_seq8_pkg::*;
#(
  parameter bit          MSB_FIRST  = 1'b0,
  parameter int unsigned GAP_CYCLES = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       out_bit,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_first,
  output logic       out_last,
  output logic [2:0] out_sel,
  output logic       busy,
  output logic [7:0] word_count
);

  localparam bit                HAS_GAP    = (GAP_CYCLES != 0);
  localparam logic [GAP_W-1:0]  GAP_LAST   = HAS_GAP ? GAP_W'(GAP_CYCLES - 1) : '0;
  localparam logic [SEL_W-1:0]  LAST_COUNT = SEL_W'(WORD_BITS - 1);

  state_e                 state_q, state_d;
  logic [WORD_BITS-1:0]   data_q, data_d;
  logic [SEL_W-1:0]       count_q, count_d;
  logic [GAP_W-1:0]       gap_q, gap_d;
  logic [7:0]             word_count_q, word_count_d;

  logic shifting;
  logic last_xfer;
  logic accept;

  assign shifting  = (state_q == SHIFT);
  assign last_xfer = shifting && out_ready && (count_q == LAST_COUNT);

  // Back-to-back acceptance only exists without a gap; reset masks the IDLE term.
  assign in_ready  = rst_n && ((state_q == IDLE) || (!HAS_GAP && last_xfer));
  assign accept    = in_ready && in_valid;

  assign out_valid  = shifting;
  assign out_first  = shifting && (count_q == '0);
  assign out_last   = shifting && (count_q == LAST_COUNT);
  assign out_sel    = shifting ? order_sel(count_q, MSB_FIRST) : '0;
  assign busy       = (state_q != IDLE);
  assign word_count = word_count_q;

  mux8x1 u_mux (
    .d (data_q),
    .s (out_sel),
    .Y (out_bit)
  );

  always_comb begin
    // NOTE: every _d defaults to its _q first, so no path leaves a latch behind.
    state_d      = state_q;
    data_d       = data_q;
    count_d      = count_q;
    gap_d        = gap_q;
    word_count_d = word_count_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          data_d  = in_data;
          count_d = '0;
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        if (last_xfer) begin
          word_count_d = word_count_q + 8'd1;
          count_d      = '0;
          if (HAS_GAP) begin
            gap_d   = '0;
            state_d = GAP;
          end else if (accept) begin
            data_d = in_data;
          end else begin
            state_d = IDLE;
          end
        end else if (out_ready) begin
          count_d = count_q + SEL_W'(1);
        end
      end

      GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      // NOTE: the data register is reset too, so out_bit is a defined 0 in reset.
      data_q       <= '0;
      count_q      <= '0;
      gap_q        <= '0;
      word_count_q <= '0;
    end else begin
      state_q      <= state_d;
      data_q       <= data_d;
      count_q      <= count_d;
      gap_q        <= gap_d;
      word_count_q <= word_count_d;
    end
  end

endmodule

// File: doc/piso_mux_seq8.md
Name: piso_mux_seq8

Overview:
- Upstream sequencer for the 8:1 gate-level multiplexer (mux8x1).
- Accepts an 8-bit word over a valid/ready handshake and holds it in a register that drives the mux d inputs.
- Steps a 3-bit select counter to drive the mux s inputs, presenting one bit per accepted transfer on a serial valid/ready stream.
- Provides parallel-to-serial conversion, using the mux as the bit picker.

Parameters:
MSB_FIRST, 0, 0 = bit 0 first (mux s = count); 1 = bit 7 first (mux s = 7 - count)
GAP_CYCLES, 0, idle cycles inserted after the last bit of a word before the next word is accepted (0..15)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_data  input  8  parallel word to serialize
in_valid  input  1  in_data valid
in_ready  output  1  block can accept a word this cycle
out_bit  output  1  current serial bit (mux8x1 Y)
out_valid  output  1  out_bit valid
out_ready  input  1  downstream accepts out_bit this cycle
out_first  output  1  out_bit is the first bit of a word
out_last  output  1  out_bit is the last bit of a word
out_sel  output  3  select value currently applied to mux s
busy  output  1  state != IDLE
word_count  output  8  words fully transmitted, modulo 256

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values (rst_n low): state IDLE, data_reg 0, count 0, gap counter 0, word_count 0.
  - Outputs during reset: out_valid 0, out_first 0, out_last 0, busy 0, in_ready 0, out_sel 0, out_bit = data_reg[0] = 0.
- States:
  - IDLE: in_ready = 1. On in_valid, latch in_data into data_reg, set count = 0, and go to SHIFT on the next edge.
  - SHIFT: out_valid = 1. out_sel = count XOR {3{MSB_FIRST}}. out_bit = mux8x1(data_reg, out_sel), purely combinational through the mux.
    - out_first = (count == 0). out_last = (count == 7).
    - A transfer occurs when out_valid and out_ready are both high. Each transfer increments count.
    - Without out_ready, all outputs hold stable; out_bit must not change while stalled.
    - On the transfer with count == 7, word_count increments (wrapping 255 -> 0), and:
      - if GAP_CYCLES == 0: in_ready is also 1 in that cycle. If in_valid is high, the new word is loaded, count resets to 0 and the state stays SHIFT (back-to-back words, no bubble). Otherwise go to IDLE.
      - if GAP_CYCLES > 0: go to GAP with the gap counter cleared.
  - GAP: out_valid 0, in_ready 0. Stay GAP_CYCLES cycles, then go to IDLE.
- in_ready is combinational: 1 in IDLE, and 1 in the final-bit transfer cycle when GAP_CYCLES == 0. It is forced 0 while rst_n is low.
- Latency: word accepted at edge N -> first bit valid in the cycle after edge N. Minimum 8 cycles per word with out_ready held high.
- in_data is ignored whenever in_ready is 0. data_reg changes only on an accepted word.
- Reset asserted mid-word: all state clears immediately (asynchronous). The partial word is discarded and word_count does not increment.
- The count wrap 7 -> 0 happens only via the final-transfer path; count never free-runs.

Decomposition:
- Shared package holds:
  - state enum (IDLE, SHIFT, GAP)
  - constant WORD_BITS = 8
  - constant SEL_W = 3
- Natural sub-module: instantiate the existing mux8x1 unmodified, with d = data_reg, s = out_sel, Y = out_bit.
- FSM, counters and handshake logic live in this module.

Test Plan:
- Reset then single word: in_data 8'hA5, MSB_FIRST 0, out_ready constant 1 -> bits 1,0,1,0,0,1,0,1 on 8 consecutive cycles. out_first on bit 0, out_last on bit 7, word_count 0 -> 1, back in IDLE.
- MSB_FIRST 1, in_data 8'h81 -> out_sel sequence 7,6,...,0. Bits 1,0,0,0,0,0,0,1.
- Backpressure: 8'h3C with out_ready toggling 1,0,0,1,... -> out_bit, out_sel and out_first/last are stable during stalls. Still exactly 8 transfers, and bit order is correct.
- Back-to-back with GAP_CYCLES 0: words 8'hFF then 8'h00 presented continuously -> 16 contiguous valid cycles, no bubble. in_ready is high in cycles 0 and 8. word_count = 2.
- GAP_CYCLES 3: two words -> exactly 3 cycles with out_valid 0 and in_ready 0 between the words, then 1 IDLE cycle with in_ready 1.
- Reset mid-word: assert rst_n low after the 4th bit of 8'hC3 -> out_valid drops asynchronously and word_count stays 0. After release, a new word 8'h01 serializes correctly from bit 0.
